// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/sequencing control for the five-stage pipeline.
// Drives pipeline register enables, ID/EX bubble, dmem handshake, timeout flag.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   id_rs, id_rt               ID source registers
//   ex_memread, ex_rt          EX load flag and destination
//   mem_memread, mem_memwrite  MEM access type
//   dmem_ready / dmem_req      data-memory handshake
//   en_pc .. en_memwb          pipeline register enables
//   bubble_idex                zero ID/EX control when loaded
//   timeout_err                sticky memory timeout
//   stall_cycles               count of cycles with en_pc low
module pipe_stall_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rt,
   input  logic        mem_memread,
   input  logic        mem_memwrite,
   input  logic        dmem_ready,
   output logic        dmem_req,
   output logic        en_pc,
   output logic        en_ifid,
   output logic        en_idex,
   output logic        en_exmem,
   output logic        en_memwb,
   output logic        bubble_idex,
   output logic        timeout_err,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {
      IDLE,
      MEM_WAIT,
      ERR
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
   logic             mem_acc, load_use;
   logic             req_c, freeze, lu_stall;

   assign mem_acc  = mem_memread | mem_memwrite;
   assign load_use = ex_memread & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (ex_rt == id_rt));

   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      req_c       = 1'b0;
      unique case (state)
         IDLE: begin
            req_c = mem_acc;
            if (mem_acc && !dmem_ready) begin
               if (MAX_WAIT == 1) begin
                  state_nx = ERR;
               end else begin
                  state_nx    = MEM_WAIT;
                  wait_cnt_nx = CNT_W'(1);
               end
            end
         end
         MEM_WAIT: begin
            req_c = 1'b1;
            if (dmem_ready) begin
               state_nx    = IDLE;
               wait_cnt_nx = '0;
            end else if (wait_cnt == LAST) begin
               state_nx = ERR;
            end else begin
               wait_cnt_nx = wait_cnt + CNT_W'(1);
            end
         end
         ERR: begin
            req_c = 1'b0;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // ERR and an unanswered request both freeze every stage; load-use
   // only applies when nothing is frozen.
   assign freeze   = (state == ERR) | (req_c & ~dmem_ready);
   assign lu_stall = ~freeze & load_use;

   // While reset is held the pipeline free-runs and no request is issued.
   assign dmem_req    = ~rst & req_c;
   assign en_pc       = rst | ~(freeze | lu_stall);
   assign en_ifid     = rst | ~(freeze | lu_stall);
   assign en_idex     = rst | ~freeze;
   assign en_exmem    = rst | ~freeze;
   assign en_memwb    = rst | ~freeze;
   assign bubble_idex = ~rst & lu_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         timeout_err  <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state       <= state_nx;
         wait_cnt    <= wait_cnt_nx;
         timeout_err <= timeout_err | (state_nx == ERR);
         if (!en_pc) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall/sequencing controller for the five-stage CPU. It generates the `en_reg` enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the bubble control for ID/EX. It also runs the request/ready handshake with a variable-latency data memory. It detects load-use hazards between EX and ID, freezes the pipeline while a data-memory access in MEM is outstanding, and latches a sticky error when the memory times out. It also keeps a free-running count of stall cycles.

## Interface
Parameters:
- `MAX_WAIT`, 16: maximum consecutive not-ready cycles allowed for one data-memory access (2..255).
- `CNT_W`, 8: width of the internal wait counter; must hold `MAX_WAIT`.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `id_rs`, `id_rt`  in  5  — source register numbers of the instruction in ID.
- `ex_memread`  in  1  — MemRead of the instruction in EX (ID/EX output).
- `ex_rt`  in  5  — destination register of the instruction in EX.
- `mem_memread`, `mem_memwrite`  in  1  — MemRead/MemWrite from the EX/MEM register outputs.
- `dmem_ready`  in  1  — data memory completes the current access this cycle.
- `dmem_req`  out  1  — data-memory access request.
- `en_pc`, `en_ifid`, `en_idex`, `en_exmem`, `en_memwb`  out  1  — register enables.
- `bubble_idex`  out  1  — forces all ID/EX control bits to 0 when loaded.
- `timeout_err`  out  1  — sticky memory-timeout flag.
- `stall_cycles`  out  32  — count of cycles with `en_pc`=0; wraps modulo 2^32.

## Operation
- FSM states: IDLE, MEM_WAIT, ERR. Registered `wait_cnt` has width `CNT_W`.
- `mem_acc = mem_memread | mem_memwrite`.
- `load_use = ex_memread & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt)`.
- `dmem_req` is 1 in either of these cases; it is 0 in ERR:
  - in IDLE when `mem_acc` is 1;
  - always in MEM_WAIT.
- Memory stall: `dmem_req`=1 and `dmem_ready`=0.
  - All five enables are 0 and `bubble_idex`=0.
  - Memory stall has priority over `load_use`.
- Load-use stall (only when there is no memory stall and the state is not ERR):
  - `en_pc`=0, `en_ifid`=0.
  - `en_idex`=1 with `bubble_idex`=1.
  - `en_exmem`=1, `en_memwb`=1.
- Otherwise all enables are 1 and `bubble_idex`=0.
- IDLE transitions:
  - `mem_acc` & !`dmem_ready` -> MEM_WAIT, `wait_cnt`<=1.
  - If `MAX_WAIT`=1, go to ERR instead.
  - `mem_acc` & `dmem_ready` -> stay in IDLE (zero-wait access, no stall).
- MEM_WAIT transitions:
  - `dmem_ready`=1 -> IDLE and `wait_cnt`<=0. The pipeline advances in this same cycle; `load_use` is evaluated normally in this cycle.
  - `dmem_ready`=0 and `wait_cnt`==`MAX_WAIT`-1 -> ERR.
  - `dmem_ready`=0 otherwise -> `wait_cnt`++.
- ERR: all enables 0, `dmem_req`=0, `bubble_idex`=0, `timeout_err`=1. Only reset leaves ERR.
- `stall_cycles` increments on every rising edge where `en_pc`=0, including ERR cycles.

## Timing
- Enables, `bubble_idex` and `dmem_req` are combinational from state and inputs; they settle in the same cycle.
- State, `wait_cnt`, `timeout_err` and `stall_cycles` update on the rising edge of `clk`.
- Reset (async, active-high, immediate): state IDLE, `wait_cnt`=0, `timeout_err`=0, `stall_cycles`=0.
  - While `rst`=1: `dmem_req`=0, all enables 1, `bubble_idex`=0.
- Reset during MEM_WAIT or ERR abandons the access. `dmem_req` drops without waiting for `dmem_ready`.
- Load-use stall lasts exactly 1 cycle per hazard: the bubble moves to EX, which clears the hazard.
- Memory latency: an access with ready on request cycle k (1-based) stalls the pipeline k-1 cycles.
  - ERR is entered at the edge ending the `MAX_WAIT`-th consecutive not-ready cycle.
  - `timeout_err` is visible the following cycle.
- `ex_rt`=0 never causes a stall.
- `dmem_ready` while `dmem_req`=0 is ignored.

## Test plan
- Load-use: `ex_memread`=1, `ex_rt`=8, `id_rs`=8, no `mem_acc` -> one cycle with `en_pc`=`en_ifid`=0, `bubble_idex`=1, `en_idex`=`en_exmem`=`en_memwb`=1; `stall_cycles` +1. Repeat with `ex_rt`=0 -> no stall.
- Zero-wait access: `mem_memread`=1, `dmem_ready`=1 -> `dmem_req`=1, all enables 1, state stays IDLE, `stall_cycles` unchanged.
- 3-cycle access: `mem_memwrite`=1, ready on the 3rd request cycle -> 2 cycles with all enables 0, 3rd cycle enables 1, then IDLE; `stall_cycles`=2.
- Priority: memory stall plus simultaneous load-use -> all enables 0 and `bubble_idex`=0 until ready. On the ready cycle, the load-use stall pattern appears.
- Timeout with `MAX_WAIT`=4:
  - Ready on the 4th request cycle -> normal completion, `timeout_err`=0.
  - No ready for 4 cycles -> `timeout_err`=1 after the 4th edge, `dmem_req`=0, enables 0, held for 10 more cycles; `stall_cycles` keeps counting.
- Async reset mid-MEM_WAIT -> outputs immediately take their reset values. After release, a new access works normally.
